// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and output stream bundle for fifo_burst_reader
`timescale 1ns/1ps

interface fifo_burst_reader_if #(
   parameter int WIDTH = 8
);
   logic             fifo_rd_en;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_error;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;

   modport master (
      output fifo_rd_en, m_valid, m_data,
      input  fifo_empty, fifo_rdata, fifo_error, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_valid, m_data,
      output fifo_empty, fifo_rdata, fifo_error, m_ready
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a burst from a 1-cycle-latency FIFO onto a valid/ready stream
`timescale 1ns/1ps

module fifo_burst_reader #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [LEN_W-1:0]      len_i,
   input  logic                  abort_i,
   fifo_burst_reader_if.master   bus_io,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [1:0]         occ_q, occ_d;
   logic               inflight_q, inflight_d;
   logic [WIDTH-1:0]   buf0_q, buf0_d;
   logic [WIDTH-1:0]   buf1_q, buf1_d;
   logic               err_q, err_d;

   logic               pop;
   logic               rd_en;
   logic [2:0]         fill;

   // fill counts words already committed to the buffer: stored plus the one on the FIFO bus
   assign pop   = (occ_q != 2'd0) & bus_io.m_ready;
   assign fill  = {1'b0, occ_q} + {2'b00, inflight_q};
   assign rd_en = (state_q == RUN) & (remaining_q != '0) & ~abort_i & ~bus_io.fifo_empty
                & (fill < (3'd2 + {2'b00, pop}));

   assign bus_io.fifo_rd_en = rd_en;
   assign bus_io.m_valid    = (occ_q != 2'd0);
   assign bus_io.m_data     = buf0_q;
   assign busy_o            = (state_q == RUN) | (state_q == DRAIN);
   assign done_o            = (state_q == DONE);
   assign err_o             = err_q;

   // buf0 is the head; a pop from a single entry leaves buf0 untouched so m_data holds
   always_comb begin
      occ_d      = occ_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      inflight_d = rd_en;
      if (inflight_q && pop) begin
         if (occ_q == 2'd2) begin
            buf0_d = buf1_q;
            buf1_d = bus_io.fifo_rdata;
         end else begin
            buf0_d = bus_io.fifo_rdata;
         end
      end else if (inflight_q) begin
         if (occ_q == 2'd0) begin
            buf0_d = bus_io.fifo_rdata;
         end else begin
            buf1_d = bus_io.fifo_rdata;
         end
         occ_d = occ_q + 2'd1;
      end else if (pop) begin
         if (occ_q == 2'd2) begin
            buf0_d = buf1_q;
         end
         occ_d = occ_q - 2'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               remaining_d = len_i;
               err_d       = 1'b0;
               state_d     = (len_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (rd_en) begin
               remaining_d = remaining_q - LEN_ONE;
            end
            if (abort_i || (rd_en && remaining_q == LEN_ONE)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (occ_q == 2'd0 && !inflight_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // an error on the same edge as a start still survives
      if (bus_io.fifo_error) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         occ_q       <= 2'd0;
         inflight_q  <= 1'b0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         occ_q       <= occ_d;
         inflight_q  <= inflight_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         err_q       <= err_d;
      end
   end

endmodule
